// File: rtl/ima_adpcm_encoder.sv
// IMA ADPCM encoder: one 16-bit PCM sample in, one 4-bit code out, 1-cycle latency.
// Optional sticky clamp flag sat_o when IMA_ENC_SAT_FLAG_EN is defined.
module ima_adpcm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcm_valid_i,
    output logic        pcm_ready_o,
    input  logic [15:0] pcm_i,
    input  logic        pcm_last_i,
    output logic        code_valid_o,
    input  logic        code_ready_i,
    output logic [3:0]  code_o,
    output logic        sop_o,
`ifdef IMA_ENC_SAT_FLAG_EN
    output logic        eop_o,
    output logic        sat_o
`else
    output logic        eop_o
`endif
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    localparam logic [14:0] StepTab [89] = '{
        15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
        15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
        15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
        15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
        15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
        15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
        15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
        15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
        15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
        15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
        15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
        15'd32767
    };

    state_e             state_q, state_d;
    logic signed [15:0] pred_q, pred_d;
    logic [6:0]         idx_q, idx_d;
    logic               code_valid_q;
    logic [3:0]         code_q;
    logic               sop_q, eop_q;

    logic               accept;
    logic [14:0]        step;
    logic [16:0]        step_w, diff, mag_a, mag_b, mag_c;
    logic               sign, b2, b1, b0;
    logic [19:0]        q_mag, q;
    logic signed [19:0] dq, sum;
    logic signed [7:0]  idx_adj, idx_sum;
    logic               clamp;

    assign pcm_ready_o  = !code_valid_q || code_ready_i;
    assign accept       = pcm_valid_i && pcm_ready_o;
    assign code_valid_o = code_valid_q;
    assign code_o       = code_q;
    assign sop_o        = sop_q;
    assign eop_o        = eop_q;

    always_comb begin
        step   = (idx_q > 7'd88) ? 15'd32767 : StepTab[idx_q];
        step_w = {2'b00, step};
        diff   = {pcm_i[15], pcm_i} - {pred_q[15], pred_q};
        sign   = diff[16];
        mag_a  = sign ? (17'd0 - diff) : diff;
        b2     = mag_a >= step_w;
        mag_b  = b2 ? (mag_a - step_w) : mag_a;
        b1     = mag_b >= (step_w >> 1);
        mag_c  = b1 ? (mag_b - (step_w >> 1)) : mag_b;
        b0     = mag_c >= (step_w >> 2);

        // Reconstruction must match the decoder bit for bit, so mirror its arithmetic exactly.
        q_mag = {5'd0, step}
              + (b2 ? {2'd0, step, 3'd0} : 20'd0)
              + (b1 ? {3'd0, step, 2'd0} : 20'd0)
              + (b0 ? {4'd0, step, 1'd0} : 20'd0);
        q     = sign ? (20'd0 - q_mag) : q_mag;
        dq    = $signed(q) >>> 3;
        sum   = $signed({{4{pred_q[15]}}, pred_q}) + dq;

        clamp  = 1'b0;
        pred_d = sum[15:0];
        if (sum > 20'sd32767) begin
            pred_d = 16'sh7fff;
            clamp  = 1'b1;
        end else if (sum < -20'sd32768) begin
            pred_d = 16'sh8000;
            clamp  = 1'b1;
        end

        idx_adj = b2 ? ($signed({5'd0, b1, b0, 1'b0}) + 8'sd2) : -8'sd1;
        idx_sum = $signed({1'b0, idx_q}) + idx_adj;
        if (idx_sum < 8'sd0) begin
            idx_d = 7'd0;
        end else if (idx_sum > 8'sd88) begin
            idx_d = 7'd88;
        end else begin
            idx_d = idx_sum[6:0];
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                StIdle:   if (!pcm_last_i) state_d = StActive;
                StActive: if (pcm_last_i)  state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pred_q       <= 16'sd0;
            idx_q        <= 7'd0;
            code_valid_q <= 1'b0;
            code_q       <= 4'd0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pred_q       <= pred_d;
                idx_q        <= idx_d;
                code_valid_q <= 1'b1;
                code_q       <= {sign, b2, b1, b0};
                sop_q        <= (state_q == StIdle);
                eop_q        <= pcm_last_i;
            end else if (code_ready_i) begin
                code_valid_q <= 1'b0;
            end
        end
    end

`ifdef IMA_ENC_SAT_FLAG_EN
    logic sat_q;
    assign sat_o = sat_q;

    // Sticky within a packet; a packet's first sample restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (accept) begin
            sat_q <= ((state_q == StIdle) ? 1'b0 : sat_q) | clamp;
        end
    end
`endif

endmodule

// File: tb/tb_ima_adpcm_encoder.sv
// Directed self-checking bench for ima_adpcm_encoder, with a reference encoder and decoder model.
module tb_ima_adpcm_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pcm_valid_i = 1'b0;
    logic        pcm_ready_o;
    logic [15:0] pcm_i = 16'd0;
    logic        pcm_last_i = 1'b0;
    logic        code_valid_o;
    logic        code_ready_i = 1'b1;
    logic [3:0]  code_o;
    logic        sop_o, eop_o;
`ifdef IMA_ENC_SAT_FLAG_EN
    logic        sat;
`endif

    int checks = 0;
    int errors = 0;

    int step_tab [89] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253,
        279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166,
        1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428,
        4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899, 15289,
        16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };
    int idx_tab [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

    int m_pred, m_idx, dec_pred, dec_idx;
    bit m_active, m_sat;

    ima_adpcm_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pcm_valid_i  (pcm_valid_i),
        .pcm_ready_o  (pcm_ready_o),
        .pcm_i        (pcm_i),
        .pcm_last_i   (pcm_last_i),
        .code_valid_o (code_valid_o),
        .code_ready_i (code_ready_i),
        .code_o       (code_o),
        .sop_o        (sop_o),
`ifdef IMA_ENC_SAT_FLAG_EN
        .eop_o        (eop_o),
        .sat_o        (sat)
`else
        .eop_o        (eop_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic recon(input int pred, input int idx, input int code,
                         output int npred, output int nidx, output bit clamp);
        int step, q;
        step = step_tab[idx];
        q = step;
        if (code[2]) q += step * 8;
        if (code[1]) q += step * 4;
        if (code[0]) q += step * 2;
        if (code[3]) q = -q;
        npred = pred + (q >>> 3);
        clamp = 1'b0;
        if (npred > 32767) begin npred = 32767; clamp = 1'b1; end
        if (npred < -32768) begin npred = -32768; clamp = 1'b1; end
        nidx = idx + idx_tab[code & 7];
        if (nidx < 0) nidx = 0;
        if (nidx > 88) nidx = 88;
    endtask

    task automatic model_reset();
        m_pred = 0; m_idx = 0; dec_pred = 0; dec_idx = 0;
        m_active = 1'b0; m_sat = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pcm_valid_i = 1'b0;
        code_ready_i = 1'b1;
        #1;
        chk("rst_valid", code_valid_o, 0);
        chk("rst_code", code_o, 0);
        chk("rst_sop_eop", {sop_o, eop_o}, 0);
        chk("rst_pred", dut.pred_q, 0);
        chk("rst_idx", dut.idx_q, 0);
`ifdef IMA_ENC_SAT_FLAG_EN
        chk("rst_sat", sat, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Encode s in the model, advancing model state; returns code and expected sop.
    task automatic model_step(input int s, input bit last, output int code, output bit sop);
        int d, m, step, c, np, ni;
        bit cl;
        d = s - m_pred;
        m = (d < 0) ? -d : d;
        step = step_tab[m_idx];
        c = 0;
        if (m >= step) begin c |= 4; m -= step; end
        if (m >= (step >> 1)) begin c |= 2; m -= (step >> 1); end
        if (m >= (step >> 2)) c |= 1;
        code = ((d < 0) ? 8 : 0) | c;
        recon(m_pred, m_idx, code, np, ni, cl);
        m_pred = np;
        m_idx = ni;
        sop = !m_active;
        m_sat = (sop ? 1'b0 : m_sat) | cl;
        if (!m_active && !last) m_active = 1'b1;
        else if (m_active && last) m_active = 1'b0;
    endtask

    task automatic push(input int s, input bit last);
        int code, guard, np, ni;
        bit sop, cl;
        logic [31:0] sv;
        sv = s;
        @(negedge clk);
        pcm_i = sv[15:0];
        pcm_last_i = last;
        pcm_valid_i = 1'b1;
        guard = 0;
        while (!pcm_ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_timeout", pcm_ready_o, 1);
        @(posedge clk);
        #1;
        pcm_valid_i = 1'b0;
        pcm_last_i = 1'b0;
        model_step(s, last, code, sop);
        chk("code", code_o, code);
        chk("sop", sop_o, sop);
        chk("eop", eop_o, last);
        chk("valid", code_valid_o, 1);
        chk("pred", dut.pred_q, m_pred);
        chk("idx", dut.idx_q, m_idx);
`ifdef IMA_ENC_SAT_FLAG_EN
        chk("sat", sat, m_sat);
`endif
        recon(dec_pred, dec_idx, int'(code_o), np, ni, cl);
        dec_pred = np;
        dec_idx = ni;
        chk("decoder_vs_pred", dut.pred_q, dec_pred);
    endtask

    initial begin
        int held;
        int sv;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", pcm_ready_o, 1);
        do_reset();

        // Zero sample as a one-sample packet.
        push(0, 1'b1);
        chk("z_code", code_o, 4'h0);
        chk("z_sop_eop", {sop_o, eop_o}, 2'b11);
        chk("z_pred", dut.pred_q, 0);
        chk("z_idx", dut.idx_q, 0);

        // Idle consume clears code_valid_o.
        @(posedge clk);
        #1;
        chk("drain_valid", code_valid_o, 0);

        do_reset();
        push(100, 1'b1);
        chk("p100_code", code_o, 4'h7);
        chk("p100_pred", dut.pred_q, 13);
        chk("p100_idx", dut.idx_q, 8);

        do_reset();
        push(-100, 1'b1);
        chk("n100_code", code_o, 4'hF);
        chk("n100_pred", dut.pred_q, -14);
        chk("n100_idx", dut.idx_q, 8);

        // Reset mid-packet: next sample starts a fresh packet.
        do_reset();
        push(1000, 1'b0);
        push(2000, 1'b0);
        do_reset();
        push(5, 1'b0);
        chk("post_rst_sop", sop_o, 1);
        push(6, 1'b0);
        chk("mid_sop", sop_o, 0);

        // Backpressure for 3 cycles with a sample waiting.
        push(3000, 1'b0);
        held = int'(code_o);
        sv = 3500;
        @(negedge clk);
        code_ready_i = 1'b0;
        pcm_i = 16'd3500;
        pcm_valid_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_code", code_o, held);
            chk("stall_valid", code_valid_o, 1);
            chk("stall_ready", pcm_ready_o, 0);
            chk("stall_pred", dut.pred_q, m_pred);
        end
        @(negedge clk);
        code_ready_i = 1'b1;
        pcm_valid_i = 1'b0;
        push(sv, 1'b0);
        push(-3000, 1'b1);
        chk("stall_eop", eop_o, 1);

        // Sine, 1 kHz at 16 kHz, with decoder tracking.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            push(int'(20000.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 16.0)), i == 63);
        end

        // Saturation run and recovery on the next packet.
        do_reset();
        for (int i = 0; i < 200; i++) push(32767, i == 199);
        chk("sat_pred_max", dut.pred_q, 32767);
`ifdef IMA_ENC_SAT_FLAG_EN
        chk("sat_set", sat, 1);
`endif
        push(0, 1'b1);
`ifdef IMA_ENC_SAT_FLAG_EN
        chk("sat_cleared", sat, 0);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
